alu_cmd_sequencer: RTL

Command front-end that sits directly upstream of the 8-bit `alu` and consumes its results. It accepts one command at a time over a valid/ready handshake and reads operands from a small register file or an immediate. It drives the ALU inputs from registers for one cycle, writes `Out` back into the register file, and presents the result with its flags downstream over a second valid/ready handshake.

---
 rtl/alu_cmd_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: serialised command front-end for the 8-bit alu with register-file writeback.
// Optional sticky carry/C flags are built when ALU_CMD_SEQ_STICKY_FLAGS_EN is defined.
module alu_cmd_sequencer #(
    parameter int          NUM_REGS  = 4,
    parameter int          REG_AW    = 2,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_srca,
    input  logic [REG_AW-1:0] cmd_srcb,
    input  logic              cmd_imm_en,
    input  logic [7:0]        cmd_imm,
    input  logic [REG_AW-1:0] cmd_dst,
    output logic [7:0]        alu_A,
    output logic [7:0]        alu_B,
    output logic [2:0]        alu_opCode,
    input  logic [7:0]        alu_Out,
    input  logic              alu_Carry_out,
    input  logic              alu_C_flag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data,
    output logic              res_carry,
    output logic              res_cflag,
    output logic [REG_AW-1:0] res_dst,
`ifdef ALU_CMD_SEQ_STICKY_FLAGS_EN
    input  logic              sticky_clr,
    output logic              sticky_carry,
    output logic              sticky_cflag,
`endif
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic [7:0] regs [NUM_REGS];
    logic [REG_AW-1:0] dst;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (cmd_valid ? EXEC : IDLE) :
                   state == EXEC ? RESP :
                   (res_ready ? IDLE : RESP);
    end
    assign cmd_ready = state == IDLE;
    assign dbg_data  = regs[dbg_addr];
    // operands are captured at accept, so a source equal to dst sees the pre-write value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opCode <= '0;
            dst        <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_carry  <= 1'b0;
            res_cflag  <= 1'b0;
            res_dst    <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                alu_A      <= regs[cmd_srca];
                alu_B      <= cmd_imm_en ? cmd_imm : regs[cmd_srcb];
                alu_opCode <= cmd_op;
                dst        <= cmd_dst;
            end
            if (state == EXEC) begin
                regs[dst] <= alu_Out;
                res_data  <= alu_Out;
                res_carry <= alu_Carry_out;
                res_cflag <= alu_C_flag;
                res_dst   <= dst;
                res_valid <= 1'b1;
            end
            if (state == RESP && res_ready) res_valid <= 1'b0;
        end
    end
`ifdef ALU_CMD_SEQ_STICKY_FLAGS_EN
    // a flag set on the EXEC edge wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_carry <= 1'b0;
            sticky_cflag <= 1'b0;
        end else begin
            sticky_carry <= (state == EXEC && alu_Carry_out) ? 1'b1 : sticky_clr ? 1'b0 : sticky_carry;
            sticky_cflag <= (state == EXEC && alu_C_flag) ? 1'b1 : sticky_clr ? 1'b0 : sticky_cflag;
        end
    end
`endif
endmodule
